sub_bytes_pipe: RTL and testbench
=================================

SUB_BYTES_PIPE -- requirements
Module: sub_bytes_pipe

Interface
REQ-001 Parameter LANES, default 4: number of byte lanes processed per word (legal 1..16).
REQ-002 Parameter INV_EN, default 1: 1 includes the inverse S-box; 0 builds forward only.
REQ-003 Parameter TAG_W, default 4: width of the sideband tag carried alongside each word (legal 1..16).
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 rst_n  input  1  asynchronous, active-low reset.
REQ-006 in_valid  input  1  input word present.
REQ-007 in_ready  output  1  block accepts input this cycle.
REQ-008 in_data  input  8*LANES  lane i = in_data[8i+7:8i].
REQ-009 in_inv  input  1  1 = inverse substitution for this word; 0 = forward.
REQ-010 in_tag  input  TAG_W  sideband, returned unchanged with the word.
REQ-011 out_valid  output  1  result word present.
REQ-012 out_ready  input  1  downstream accepts result.
REQ-013 out_data  output  8*LANES  substituted word, same lane order.
REQ-014 out_inv  output  1  mode used for this word.
REQ-015 out_tag  output  TAG_W  tag of this word.
REQ-016 busy  output  1  high when either pipeline stage holds a valid word.

Function
REQ-017 Each lane SHALL apply the AES forward S-box (FIPS-197) when inv=0 and the AES inverse S-box when inv=1.
REQ-018 When INV_EN=0, in_inv SHALL be ignored, forward substitution SHALL be applied, and out_inv SHALL read 0.
REQ-019 Transfer SHALL occur on valid&ready at a clock edge, on both ports.
REQ-020 The pipeline SHALL have two stages: S1 registers data/inv/tag; S2 registers the lookup result.
REQ-021 Latency SHALL be exactly 2 cycles from input transfer to out_valid when out_ready is held high.
REQ-022 Throughput SHALL be one word per cycle with out_ready held high.
REQ-023 S2 load enable = !s2_valid | out_ready; S1 load enable = !s1_valid | S2 load enable; in_ready = S1 load enable.
REQ-024 With out_valid high and out_ready low, out_data/out_inv/out_tag SHALL remain stable and no word SHALL be dropped or duplicated.
REQ-025 Simultaneous output pop and input push with both stages full SHALL advance all stages in the same cycle.
REQ-026 Mode SHALL be per word; alternating in_inv on consecutive words SHALL produce correct results with no bubbles.
REQ-027 in_data is don't-care when in_valid=0; no state SHALL change from it.

Reset
REQ-028 Asserting rst_n low SHALL immediately clear s1_valid and s2_valid; out_valid=0, busy=0.
REQ-029 Data, mode and tag registers need no reset; out_data SHALL be treated as don't-care while out_valid=0.
REQ-030 Words in flight at reset SHALL be discarded; the first transfer after deassertion SHALL behave as from idle.
REQ-031 in_ready SHALL be 1 in the first cycle after reset deassertion.

Structure
REQ-032 Shared package aes_pkg SHALL hold the 256-entry forward and inverse S-box constant tables and the byte type.
REQ-033 One sub-module, sbox_dual (8-bit in, inv select, 8-bit out, combinational, INV_EN parameter), SHALL be instantiated LANES times between S1 and S2.

Verification
REQ-034 Forward: LANES=4, in_data=0x00_53_01_FF, inv=0 -> out_data=0x63_ED_7C_16 after 2 cycles, tag echoed.
REQ-035 Inverse: in_data=0x63_ED_7C_16, inv=1 -> out_data=0x00_53_01_FF; full 256-value round trip forward then inverse returns the input in every lane.
REQ-036 Backpressure: 8 back-to-back words with tags 0..7, out_ready low for cycles 3..6 -> in_ready low once both stages are full; all 8 words are delivered in order, stable while stalled.
REQ-037 Reset mid-operation: two words in flight, rst_n pulsed low -> out_valid drops immediately, neither word is emitted, and the next word appears 2 cycles after acceptance.
REQ-038 INV_EN=0 build: in_inv=1 with 0x53 -> out_data byte 0xED, out_inv=0.

Source files
------------

// File: rtl/aes_pkg.sv
// AES byte type and the FIPS-197 forward/inverse S-box tables, shared by the
// per-lane substitution logic.
package aes_pkg;

  typedef logic [7:0] byte_t;

  localparam byte_t SBOX_FWD [256] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  localparam byte_t SBOX_INV [256] = '{
    8'h52, 8'h09, 8'h6a, 8'hd5, 8'h30, 8'h36, 8'ha5, 8'h38, 8'hbf, 8'h40, 8'ha3, 8'h9e, 8'h81, 8'hf3, 8'hd7, 8'hfb,
    8'h7c, 8'he3, 8'h39, 8'h82, 8'h9b, 8'h2f, 8'hff, 8'h87, 8'h34, 8'h8e, 8'h43, 8'h44, 8'hc4, 8'hde, 8'he9, 8'hcb,
    8'h54, 8'h7b, 8'h94, 8'h32, 8'ha6, 8'hc2, 8'h23, 8'h3d, 8'hee, 8'h4c, 8'h95, 8'h0b, 8'h42, 8'hfa, 8'hc3, 8'h4e,
    8'h08, 8'h2e, 8'ha1, 8'h66, 8'h28, 8'hd9, 8'h24, 8'hb2, 8'h76, 8'h5b, 8'ha2, 8'h49, 8'h6d, 8'h8b, 8'hd1, 8'h25,
    8'h72, 8'hf8, 8'hf6, 8'h64, 8'h86, 8'h68, 8'h98, 8'h16, 8'hd4, 8'ha4, 8'h5c, 8'hcc, 8'h5d, 8'h65, 8'hb6, 8'h92,
    8'h6c, 8'h70, 8'h48, 8'h50, 8'hfd, 8'hed, 8'hb9, 8'hda, 8'h5e, 8'h15, 8'h46, 8'h57, 8'ha7, 8'h8d, 8'h9d, 8'h84,
    8'h90, 8'hd8, 8'hab, 8'h00, 8'h8c, 8'hbc, 8'hd3, 8'h0a, 8'hf7, 8'he4, 8'h58, 8'h05, 8'hb8, 8'hb3, 8'h45, 8'h06,
    8'hd0, 8'h2c, 8'h1e, 8'h8f, 8'hca, 8'h3f, 8'h0f, 8'h02, 8'hc1, 8'haf, 8'hbd, 8'h03, 8'h01, 8'h13, 8'h8a, 8'h6b,
    8'h3a, 8'h91, 8'h11, 8'h41, 8'h4f, 8'h67, 8'hdc, 8'hea, 8'h97, 8'hf2, 8'hcf, 8'hce, 8'hf0, 8'hb4, 8'he6, 8'h73,
    8'h96, 8'hac, 8'h74, 8'h22, 8'he7, 8'had, 8'h35, 8'h85, 8'he2, 8'hf9, 8'h37, 8'he8, 8'h1c, 8'h75, 8'hdf, 8'h6e,
    8'h47, 8'hf1, 8'h1a, 8'h71, 8'h1d, 8'h29, 8'hc5, 8'h89, 8'h6f, 8'hb7, 8'h62, 8'h0e, 8'haa, 8'h18, 8'hbe, 8'h1b,
    8'hfc, 8'h56, 8'h3e, 8'h4b, 8'hc6, 8'hd2, 8'h79, 8'h20, 8'h9a, 8'hdb, 8'hc0, 8'hfe, 8'h78, 8'hcd, 8'h5a, 8'hf4,
    8'h1f, 8'hdd, 8'ha8, 8'h33, 8'h88, 8'h07, 8'hc7, 8'h31, 8'hb1, 8'h12, 8'h10, 8'h59, 8'h27, 8'h80, 8'hec, 8'h5f,
    8'h60, 8'h51, 8'h7f, 8'ha9, 8'h19, 8'hb5, 8'h4a, 8'h0d, 8'h2d, 8'he5, 8'h7a, 8'h9f, 8'h93, 8'hc9, 8'h9c, 8'hef,
    8'ha0, 8'he0, 8'h3b, 8'h4d, 8'hae, 8'h2a, 8'hf5, 8'hb0, 8'hc8, 8'heb, 8'hbb, 8'h3c, 8'h83, 8'h53, 8'h99, 8'h61,
    8'h17, 8'h2b, 8'h04, 8'h7e, 8'hba, 8'h77, 8'hd6, 8'h26, 8'he1, 8'h69, 8'h14, 8'h63, 8'h55, 8'h21, 8'h0c, 8'h7d
  };

endpackage

// File: rtl/sbox_dual.sv
// Combinational single-byte AES substitution; the inverse table is only
// reachable (and thus only kept by synthesis) when INV_EN is set.
module sbox_dual
  import aes_pkg::*;
#(
  parameter bit INV_EN = 1'b1
) (
  input  logic [7:0] byte_i,
  input  logic       inv_i,
  output logic [7:0] byte_o
);

  // table select
  always_comb begin
    byte_o = 8'h00;
    if (INV_EN && inv_i) begin
      byte_o = SBOX_INV[byte_i];
    end else begin
      byte_o = SBOX_FWD[byte_i];
    end
  end

endmodule

// File: rtl/sub_bytes_pipe.sv
// Two-stage valid/ready SubBytes pipeline: S1 captures the input word, the
// per-lane S-boxes sit between S1 and S2, S2 holds the result for the output.
module sub_bytes_pipe
  import aes_pkg::*;
#(
  parameter int unsigned LANES  = 4,
  parameter bit          INV_EN = 1'b1,
  parameter int unsigned TAG_W  = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [8*LANES-1:0] in_data,
  input  logic               in_inv,
  input  logic [TAG_W-1:0]   in_tag,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [8*LANES-1:0] out_data,
  output logic               out_inv,
  output logic [TAG_W-1:0]   out_tag,
  output logic               busy
);

  logic               s1_valid_q, s1_valid_d;
  logic               s2_valid_q, s2_valid_d;
  logic [8*LANES-1:0] s1_data_q, s2_data_q, sub_s;
  logic               s1_inv_q, s2_inv_q;
  logic [TAG_W-1:0]   s1_tag_q, s2_tag_q;
  logic               s1_load_s, s2_load_s, s1_cap_s, s2_cap_s;

  // a stage may load when empty or when the stage after it is moving
  always_comb begin
    s2_load_s  = !s2_valid_q || out_ready;
    s1_load_s  = !s1_valid_q || s2_load_s;
    s1_cap_s   = s1_load_s && in_valid;
    s2_cap_s   = s2_load_s && s1_valid_q;
    s1_valid_d = s1_valid_q;
    s2_valid_d = s2_valid_q;
    if (s1_load_s) begin
      s1_valid_d = in_valid;
    end else begin
      s1_valid_d = s1_valid_q;
    end
    if (s2_load_s) begin
      s2_valid_d = s1_valid_q;
    end else begin
      s2_valid_d = s2_valid_q;
    end
  end

  // stage occupancy, cleared asynchronously so in-flight words are dropped
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q <= 1'b0;
      s2_valid_q <= 1'b0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s2_valid_q <= s2_valid_d;
    end
  end

  // payload registers: unreset, written only on a real transfer
  always_ff @(posedge clk) begin
    if (s1_cap_s) begin
      s1_data_q <= in_data;
      s1_inv_q  <= in_inv && INV_EN;
      s1_tag_q  <= in_tag;
    end
    if (s2_cap_s) begin
      s2_data_q <= sub_s;
      s2_inv_q  <= s1_inv_q;
      s2_tag_q  <= s1_tag_q;
    end
  end

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    sbox_dual #(.INV_EN(INV_EN)) u_sbox (
      .byte_i (s1_data_q[8*i +: 8]),
      .inv_i  (s1_inv_q),
      .byte_o (sub_s[8*i +: 8])
    );
  end

  assign in_ready  = s1_load_s;
  assign out_valid = s2_valid_q;
  assign out_data  = s2_data_q;
  assign out_inv   = s2_inv_q;
  assign out_tag   = s2_tag_q;
  assign busy      = s1_valid_q || s2_valid_q;

endmodule

// File: tb/tb_sub_bytes_pipe.sv
// Scoreboard bench for sub_bytes_pipe: a driver pushes expectations on input
// transfer, negedge monitors pop and compare on output transfer.
module tb_sub_bytes_pipe;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, in_ready, in_inv, out_valid, out_ready, out_inv, busy;
  logic [31:0] in_data, out_data;
  logic [3:0]  in_tag, out_tag;

  logic        b_in_valid, b_in_ready, b_in_inv, b_out_valid, b_out_inv, b_busy;
  logic [31:0] b_in_data, b_out_data;
  logic [3:0]  b_in_tag, b_out_tag;

  typedef struct {
    logic [31:0] data;
    logic        inv;
    logic [3:0]  tag;
    bit          chk_data;
    bit          capture;
    bit          chk_lat;
    int          acc;
  } exp_t;

  exp_t        sb[$];
  exp_t        sb2[$];
  logic [31:0] fwd_res[$];
  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  sub_bytes_pipe #(.LANES(4), .INV_EN(1'b1), .TAG_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_inv(in_inv), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_inv(out_inv), .out_tag(out_tag), .busy(busy)
  );

  sub_bytes_pipe #(.LANES(4), .INV_EN(1'b0), .TAG_W(4)) dut_fwd (
    .clk(clk), .rst_n(rst_n), .in_valid(b_in_valid), .in_ready(b_in_ready),
    .in_data(b_in_data), .in_inv(b_in_inv), .in_tag(b_in_tag),
    .out_valid(b_out_valid), .out_ready(1'b1), .out_data(b_out_data),
    .out_inv(b_out_inv), .out_tag(b_out_tag), .busy(b_busy)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // main monitor: pop on transfer, hold-stable check while stalled
  exp_t        e_mon;
  bit          stall_seen = 1'b0;
  logic [31:0] st_data;
  logic        st_inv;
  logic [3:0]  st_tag;
  always @(negedge clk) begin
    if (!rst_n) begin
      stall_seen = 1'b0;
    end else begin
      if (stall_seen) begin
        check("stall_valid", 32'(out_valid), 32'd1);
        check("stall_data", out_data, st_data);
        check("stall_inv", 32'(out_inv), 32'(st_inv));
        check("stall_tag", 32'(out_tag), 32'(st_tag));
      end
      stall_seen = out_valid && !out_ready;
      st_data = out_data;
      st_inv  = out_inv;
      st_tag  = out_tag;
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_output: got tag %h data %h expected no word", out_tag, out_data);
        end else begin
          e_mon = sb.pop_front();
          check("out_tag", 32'(out_tag), 32'(e_mon.tag));
          check("out_inv", 32'(out_inv), 32'(e_mon.inv));
          if (e_mon.chk_data) check("out_data", out_data, e_mon.data);
          if (e_mon.capture) fwd_res.push_back(out_data);
          if (e_mon.chk_lat) check("latency", 32'(cyc - e_mon.acc), 32'd2);
        end
      end
    end
  end

  // forward-only instance monitor
  exp_t e_mon2;
  always @(negedge clk) begin
    if (rst_n && b_out_valid) begin
      if (sb2.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL fwd_unexpected: got data %h expected no word", b_out_data);
      end else begin
        e_mon2 = sb2.pop_front();
        check("fwd_data", b_out_data, e_mon2.data);
        check("fwd_inv", 32'(b_out_inv), 32'(e_mon2.inv));
        check("fwd_tag", 32'(b_out_tag), 32'(e_mon2.tag));
      end
    end
  end

  task automatic sync();
    @(posedge clk);
    #1;
  endtask

  // called at posedge+1; returns at posedge+1 after the word is accepted
  task automatic send(input logic [31:0] d, input logic inv, input logic [3:0] tag,
                      input bit chk, input bit cap, input bit lat, input logic [31:0] expd);
    exp_t e;
    int   n = 0;
    in_valid = 1'b1;
    in_data  = d;
    in_inv   = inv;
    in_tag   = tag;
    @(negedge clk);
    while (!in_ready && n < 50) begin
      n++;
      @(negedge clk);
    end
    if (!in_ready) begin
      checks++;
      errors++;
      $display("FAIL send_timeout: got in_ready 0 expected 1 for tag %h", tag);
    end else begin
      e.data = expd; e.inv = inv; e.tag = tag;
      e.chk_data = chk; e.capture = cap; e.chk_lat = lat; e.acc = cyc;
      sb.push_back(e);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_drain();
    int n = 0;
    while ((sb.size() != 0 || sb2.size() != 0 || busy || b_busy) && n < 300) begin
      n++;
      @(negedge clk);
    end
    check("drain", 32'(sb.size() + sb2.size()), 32'd0);
  endtask

  logic [7:0] bp_exp [8] = '{8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5};
  bit         saw_low;
  int         t0;

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; in_data = 32'h0; in_inv = 1'b0; in_tag = 4'h0;
    out_ready = 1'b1;
    b_in_valid = 1'b0; b_in_data = 32'h0; b_in_inv = 1'b0; b_in_tag = 4'h0;
    #12;
    check("reset_out_valid", 32'(out_valid), 32'd0);
    check("reset_busy", 32'(busy), 32'd0);
    sync();
    rst_n = 1'b1;
    @(negedge clk);
    check("ready_after_reset", 32'(in_ready), 32'd1);

    // directed forward / inverse words
    sync();
    send(32'h005301FF, 1'b0, 4'h5, 1'b1, 1'b0, 1'b1, 32'h63ED7C16);
    send(32'h63ED7C16, 1'b1, 4'hA, 1'b1, 1'b0, 1'b1, 32'h005301FF);
    // alternating mode, back to back
    send(32'h00000000, 1'b0, 4'h1, 1'b1, 1'b0, 1'b1, 32'h63636363);
    send(32'h63636363, 1'b1, 4'h2, 1'b1, 1'b0, 1'b1, 32'h00000000);
    send(32'h10203040, 1'b0, 4'h3, 1'b1, 1'b0, 1'b1, 32'hCAB70409);
    send(32'h167C00FF, 1'b1, 4'h4, 1'b1, 1'b0, 1'b1, 32'hFF01527D);
    wait_drain();

    // all 256 byte values forward, then back through the inverse
    sync();
    for (int i = 0; i < 64; i++) begin
      logic [7:0] b;
      b = 8'(i * 4);
      send({b + 8'd3, b + 8'd2, b + 8'd1, b}, 1'b0, 4'(i), 1'b0, 1'b1, 1'b1, 32'h0);
    end
    wait_drain();
    check("round_trip_count", 32'(fwd_res.size()), 32'd64);
    sync();
    for (int i = 0; i < 64 && i < fwd_res.size(); i++) begin
      logic [7:0] b;
      b = 8'(i * 4);
      send(fwd_res[i], 1'b1, 4'(i), 1'b1, 1'b0, 1'b1, {b + 8'd3, b + 8'd2, b + 8'd1, b});
    end
    wait_drain();

    // backpressure: out_ready low in cycles 3..6 of an 8-word burst
    sync();
    t0 = cyc;
    saw_low = 1'b0;
    fork
      begin
        for (int k = 0; k < 8; k++) begin
          send({4{8'(k)}}, 1'b0, 4'(k), 1'b1, 1'b0, 1'b0, {4{bp_exp[k]}});
        end
      end
      begin
        repeat (14) begin
          out_ready = !((cyc - t0) >= 3 && (cyc - t0) <= 6);
          @(posedge clk);
          #1;
        end
        out_ready = 1'b1;
      end
      begin
        repeat (14) begin
          @(negedge clk);
          if (!in_ready) saw_low = 1'b1;
        end
      end
    join
    wait_drain();
    check("bp_in_ready_low", 32'(saw_low), 32'd1);

    // reset with two words in flight, output stalled
    sync();
    out_ready = 1'b0;
    send(32'h11111111, 1'b0, 4'hB, 1'b1, 1'b0, 1'b0, 32'h82828282);
    send(32'h22222222, 1'b0, 4'hC, 1'b1, 1'b0, 1'b0, 32'h93939393);
    check("pre_reset_valid", 32'(out_valid), 32'd1);
    check("pre_reset_busy", 32'(busy), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("reset_drop_valid", 32'(out_valid), 32'd0);
    check("reset_drop_busy", 32'(busy), 32'd0);
    sb.delete();
    @(negedge clk);
    sync();
    rst_n = 1'b1;
    out_ready = 1'b1;
    send(32'h33333333, 1'b0, 4'hD, 1'b1, 1'b0, 1'b1, 32'hC3C3C3C3);
    wait_drain();

    // forward-only build ignores in_inv
    sync();
    b_in_valid = 1'b1;
    b_in_data  = 32'h00000053;
    b_in_inv   = 1'b1;
    b_in_tag   = 4'h3;
    @(negedge clk);
    check("fwd_in_ready", 32'(b_in_ready), 32'd1);
    if (b_in_ready) sb2.push_back('{32'h636363ED, 1'b0, 4'h3, 1'b1, 1'b0, 1'b0, cyc});
    sync();
    b_in_valid = 1'b0;
    wait_drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

endmodule
